// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control unit.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b1000;
    localparam logic [3:0] ALUC_SLL = 4'b0001;
    localparam logic [3:0] ALUC_XOR = 4'b0100;
    localparam logic [3:0] ALUC_SRL = 4'b0101;
    localparam logic [3:0] ALUC_SRA = 4'b1101;
    localparam logic [3:0] ALUC_OR  = 4'b0110;
    localparam logic [3:0] ALUC_AND = 4'b0111;
    localparam logic [3:0] ALUC_LUI = 4'b0010;
    localparam logic [3:0] ALUC_BLT = 4'b1011;
    localparam logic [3:0] ALUC_JAL = 4'b1111;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;
    localparam logic [1:0] PC_JAL  = 2'b11;

    // Static decode of the IR: instruction class plus state-independent ALU controls.
    typedef struct packed {
        logic       bad;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       is_bne;
        logic       is_blt;
        logic       is_jal;
        logic       is_jalr;
        logic [3:0] aluc;
        logic       aluimm;
        logic       sext;
        logic       shift;
        logic       i_lui;
    } dec_t;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational instruction decoder: IR -> class one-hots and static ALU controls.
module mc_cu_decode
    import mc_cu_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec_c
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       alt;
    logic       arith_ok;
    logic       is_shift;
    logic [3:0] arith_op;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign func3       = inst[14:12];
    assign alt         = inst[30];
    assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};
    assign is_shift    = (func3 == F3_SLL) || (func3 == F3_SR);

    // ALU op shared by register and immediate arithmetic; alt selects sub (R only) and sra.
    always_comb begin
        arith_ok = 1'b1;
        arith_op = ALUC_ADD;
        case (func3)
            F3_ADD:  arith_op = (opcode == OP_R && alt) ? ALUC_SUB : ALUC_ADD;
            F3_SLL:  arith_op = ALUC_SLL;
            F3_XOR:  arith_op = ALUC_XOR;
            F3_SR:   arith_op = alt ? ALUC_SRA : ALUC_SRL;
            F3_OR:   arith_op = ALUC_OR;
            F3_AND:  arith_op = ALUC_AND;
            default: arith_ok = 1'b0;
        endcase
    end

    // Opcode class decode; anything not listed is flagged bad.
    always_comb begin
        dec_c = '0;
        case (opcode)
            OP_R: begin
                dec_c.bad  = ~arith_ok;
                dec_c.aluc = arith_op;
            end
            OP_I: begin
                dec_c.bad    = ~arith_ok;
                dec_c.aluc   = arith_op;
                dec_c.aluimm = 1'b1;
                dec_c.shift  = is_shift;
                dec_c.sext   = ~is_shift;
            end
            OP_LUI: begin
                dec_c.aluc   = ALUC_LUI;
                dec_c.aluimm = 1'b1;
                dec_c.i_lui  = 1'b1;
            end
            OP_LW: begin
                dec_c.bad    = (func3 != F3_W);
                dec_c.is_lw  = 1'b1;
                dec_c.aluimm = 1'b1;
                dec_c.sext   = 1'b1;
            end
            OP_SW: begin
                dec_c.bad    = (func3 != F3_W);
                dec_c.is_sw  = 1'b1;
                dec_c.aluimm = 1'b1;
                dec_c.sext   = 1'b1;
            end
            OP_BR: begin
                case (func3)
                    F3_BEQ: begin
                        dec_c.is_beq = 1'b1;
                        dec_c.aluc   = ALUC_SUB;
                    end
                    F3_BNE: begin
                        dec_c.is_bne = 1'b1;
                        dec_c.aluc   = ALUC_SUB;
                    end
                    F3_BLT: begin
                        dec_c.is_blt = 1'b1;
                        dec_c.aluc   = ALUC_BLT;
                    end
                    default: dec_c.bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec_c.is_jal = 1'b1;
                dec_c.aluc   = ALUC_JAL;
            end
            OP_JALR: begin
                dec_c.bad     = (func3 != F3_JALR);
                dec_c.is_jalr = 1'b1;
                dec_c.aluimm  = 1'b1;
                dec_c.sext    = 1'b1;
            end
            default: dec_c.bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB over a shared ALU and memory port.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
)
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] inst,
    input  logic        z,
    input  logic        flag_small,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pcsource,
    output logic        wreg,
    output logic        wmem,
    output logic        m2reg,
    output logic [3:0]  aluc,
    output logic        aluimm,
    output logic        sext,
    output logic        shift,
    output logic        i_lui,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    state_t             state_r;
    state_t             state_nxt;
    dec_t               dec;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_last;
    logic               timeout_c;
    logic               illegal_c;
    logic               is_branch;
    logic               taken;

    mc_cu_decode u_decode (
        .inst  (inst),
        .dec_c (dec)
    );

    assign state     = state_r;
    assign wait_last = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign is_branch = dec.is_beq | dec.is_bne | dec.is_blt;
    assign taken     = (dec.is_beq & z) | (dec.is_bne & ~z) | (dec.is_blt & flag_small);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Memory wait counter (restarts on every state change) and sticky error flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (state_nxt != state_r) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timeout_c) begin
                bus_err <= 1'b1;
            end
            if (illegal_c) begin
                illegal <= 1'b1;
            end
        end
    end

    // Next state and per-state datapath strobes; everything forced low while in reset.
    always_comb begin
        state_nxt = state_r;
        mem_req   = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsource  = PC_SEQ;
        wreg      = 1'b0;
        wmem      = 1'b0;
        m2reg     = 1'b0;
        aluc      = ALUC_ADD;
        aluimm    = 1'b0;
        sext      = 1'b0;
        shift     = 1'b0;
        i_lui     = 1'b0;
        timeout_c = 1'b0;
        illegal_c = 1'b0;

        case (state_r)
            S_IDLE: state_nxt = S_IF;
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_ID;
                end else if (wait_last) begin
                    timeout_c = 1'b1;
                    state_nxt = S_TRAP;
                end
            end
            S_ID: begin
                if (dec.bad) begin
                    illegal_c = 1'b1;
                    state_nxt = S_TRAP;
                end else begin
                    state_nxt = S_EX;
                end
            end
            S_EX: begin
                aluc   = dec.aluc;
                aluimm = dec.aluimm;
                sext   = dec.sext;
                shift  = dec.shift;
                i_lui  = dec.i_lui;
                if (is_branch) begin
                    pc_we     = taken;
                    pcsource  = PC_BR;
                    state_nxt = S_IF;
                end else if (dec.is_lw || dec.is_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = dec.is_sw;
                if (mem_ready) begin
                    state_nxt = dec.is_sw ? S_IF : S_WB;
                end else if (wait_last) begin
                    timeout_c = 1'b1;
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                wreg  = 1'b1;
                m2reg = dec.is_lw;
                if (dec.is_jal) begin
                    pc_we    = 1'b1;
                    pcsource = PC_JAL;
                end else if (dec.is_jalr) begin
                    pc_we    = 1'b1;
                    pcsource = PC_JALR;
                end
                state_nxt = S_IF;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_IDLE;
        endcase

        if (!resetn) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pcsource = PC_SEQ;
            wreg     = 1'b0;
            wmem     = 1'b0;
            m2reg    = 1'b0;
            aluc     = ALUC_ADD;
            aluimm   = 1'b0;
            sext     = 1'b0;
            shift    = 1'b0;
            i_lui    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: directed and random instructions traced cycle by cycle against a table model.
module tb_mc_cu;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] O_R    = 7'h33;
    localparam logic [6:0] O_I    = 7'h13;
    localparam logic [6:0] O_LUI  = 7'h37;
    localparam logic [6:0] O_LW   = 7'h03;
    localparam logic [6:0] O_SW   = 7'h23;
    localparam logic [6:0] O_BR   = 7'h63;
    localparam logic [6:0] O_JAL  = 7'h6F;
    localparam logic [6:0] O_JALR = 7'h67;

    localparam int K_ALU = 0, K_LUI = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_BAD = 7;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] inst;
    logic        z, flag_small, mem_ready;
    logic        mem_req, iord, ir_we, pc_we, wreg, wmem, m2reg;
    logic        aluimm, sext, shift, i_lui, illegal, bus_err;
    logic [1:0]  pcsource;
    logic [3:0]  aluc;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, iord, ir_we, pc_we;
        logic [1:0] pcsrc;
        logic       wreg, wmem, m2reg;
        logic [3:0] aluc;
        logic       aluimm, sext, shift, lui;
    } obs_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        int         f3;     // -1: free field; for bad entries selects the corruption mode
        int         b30;    // -1: free bit
        logic [3:0] aluc;
        bit         imm;
        bit         sh;
        int         kind;
        int         br;     // 1 beq, 2 bne, 3 blt
    } ent_t;

    obs_t obs, want;

    assign obs = {state, mem_req, iord, ir_we, pc_we, pcsource, wreg, wmem, m2reg,
                  aluc, aluimm, sext, shift, i_lui};

    mc_cu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .inst       (inst),
        .z          (z),
        .flag_small (flag_small),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pcsource   (pcsource),
        .wreg       (wreg),
        .wmem       (wmem),
        .m2reg      (m2reg),
        .aluc       (aluc),
        .aluimm     (aluimm),
        .sext       (sext),
        .shift      (shift),
        .i_lui      (i_lui),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic ent_t mk(string n, logic [6:0] op, int f3, int b30, logic [3:0] al,
                                bit imm, bit sh, int kind, int br);
        ent_t e;
        e.name = n; e.op = op; e.f3 = f3; e.b30 = b30; e.aluc = al;
        e.imm = imm; e.sh = sh; e.kind = kind; e.br = br;
        return e;
    endfunction

    // Instruction table: encoding fields and the controls the EX cycle must show.
    function automatic ent_t entry(int k);
        case (k)
            0:  return mk("add",  O_R, 0, 0, 4'h0, 0, 0, K_ALU, 0);
            1:  return mk("sub",  O_R, 0, 1, 4'h8, 0, 0, K_ALU, 0);
            2:  return mk("sll",  O_R, 1, 0, 4'h1, 0, 0, K_ALU, 0);
            3:  return mk("xor",  O_R, 4, 0, 4'h4, 0, 0, K_ALU, 0);
            4:  return mk("srl",  O_R, 5, 0, 4'h5, 0, 0, K_ALU, 0);
            5:  return mk("sra",  O_R, 5, 1, 4'hD, 0, 0, K_ALU, 0);
            6:  return mk("or",   O_R, 6, 0, 4'h6, 0, 0, K_ALU, 0);
            7:  return mk("and",  O_R, 7, 0, 4'h7, 0, 0, K_ALU, 0);
            8:  return mk("addi", O_I, 0, -1, 4'h0, 1, 0, K_ALU, 0);
            9:  return mk("slli", O_I, 1, 0, 4'h1, 1, 1, K_ALU, 0);
            10: return mk("xori", O_I, 4, -1, 4'h4, 1, 0, K_ALU, 0);
            11: return mk("srli", O_I, 5, 0, 4'h5, 1, 1, K_ALU, 0);
            12: return mk("srai", O_I, 5, 1, 4'hD, 1, 1, K_ALU, 0);
            13: return mk("ori",  O_I, 6, -1, 4'h6, 1, 0, K_ALU, 0);
            14: return mk("andi", O_I, 7, -1, 4'h7, 1, 0, K_ALU, 0);
            15: return mk("lui",  O_LUI, -1, -1, 4'h2, 1, 0, K_LUI, 0);
            16: return mk("lw",   O_LW, 2, -1, 4'h0, 1, 0, K_LW, 0);
            17: return mk("sw",   O_SW, 2, -1, 4'h0, 1, 0, K_SW, 0);
            18: return mk("beq",  O_BR, 0, -1, 4'h8, 0, 0, K_BR, 1);
            19: return mk("bne",  O_BR, 1, -1, 4'h8, 0, 0, K_BR, 2);
            20: return mk("blt",  O_BR, 4, -1, 4'hB, 0, 0, K_BR, 3);
            21: return mk("jal",  O_JAL, -1, -1, 4'hF, 0, 0, K_JAL, 0);
            22: return mk("jalr", O_JALR, 0, -1, 4'h0, 1, 0, K_JALR, 0);
            23: return mk("badop", 7'h0, 0, -1, 4'h0, 0, 0, K_BAD, 0);
            default: return mk("badf3", 7'h0, 1, -1, 4'h0, 0, 0, K_BAD, 0);
        endcase
    endfunction

    function automatic bit legal_op(logic [6:0] op);
        return op inside {O_R, O_I, O_LUI, O_LW, O_SW, O_BR, O_JAL, O_JALR};
    endfunction

    function automatic bit f3_ok(logic [6:0] op, logic [2:0] f3);
        case (op)
            O_R, O_I:    return !(f3 inside {3'd2, 3'd3});
            O_LW, O_SW:  return f3 == 3'd2;
            O_BR:        return f3 inside {3'd0, 3'd1, 3'd4};
            O_JALR:      return f3 == 3'd0;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] encode(ent_t e);
        logic [31:0] w;
        w = $urandom;
        if (e.kind == K_BAD) begin
            if (e.f3 == 0) begin
                while (legal_op(w[6:0])) w[6:0] = 7'($urandom);
            end else begin
                case ($urandom_range(0, 5))
                    0: w[6:0] = O_R;
                    1: w[6:0] = O_I;
                    2: w[6:0] = O_LW;
                    3: w[6:0] = O_SW;
                    4: w[6:0] = O_BR;
                    default: w[6:0] = O_JALR;
                endcase
                while (f3_ok(w[6:0], w[14:12])) w[14:12] = 3'($urandom);
            end
        end else begin
            w[6:0] = e.op;
            if (e.f3 >= 0) w[14:12] = 3'(e.f3);
            if (e.b30 >= 0) w[30] = e.b30[0];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, exp_v);
        end
    endtask

    task automatic chk_bus(input string tag);
        chk(tag, 32'(obs), 32'(want));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset pulse, checks outputs low during and just after it; returns at the start of IF.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        #1;
        want = '0;
        chk_bus({tag, "_rst"});
        chk({tag, "_rstflags"}, 32'({illegal, bus_err}), 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        want = '0;
        chk_bus({tag, "_idle"});
        tick();
    endtask

    task automatic end_ok(input string tag);
        chk({tag, "_flags"}, 32'({illegal, bus_err}), 32'd0);
    endtask

    // Memory access phase (IF or MEM) with w stall cycles; done=1 when the instruction ended early.
    task automatic mem_phase(input string tag, input int w, input bit in_mem, input bit sw,
                             input bit abort, output bit done);
        bit to;
        to   = 1'b0;
        done = 1'b0;
        for (int c = 0; c <= w; c++) begin
            if (c == TIMEOUT) begin
                to = 1'b1;
                break;
            end
            mem_ready = (c == w);
            #1;
            want         = '0;
            want.st      = in_mem ? 3'd4 : 3'd1;
            want.mem_req = 1'b1;
            want.iord    = in_mem;
            want.wmem    = in_mem & sw;
            want.ir_we   = !in_mem && (c == w);
            want.pc_we   = !in_mem && (c == w);
            chk_bus($sformatf("%s_c%0d", tag, c));
            if (abort && in_mem && c == 0) begin
                do_reset({tag, "_abort"});
                done = 1'b1;
                return;
            end
            tick();
        end
        if (to) begin
            for (int c = 0; c < 2; c++) begin
                mem_ready = 1'b1;
                #1;
                want    = '0;
                want.st = 3'd6;
                chk_bus({tag, "_trap"});
                chk({tag, "_buserr"}, 32'({illegal, bus_err}), 32'd1);
                tick();
            end
            do_reset({tag, "_to"});
            done = 1'b1;
        end
    endtask

    // One instruction from the start of IF to the start of the next IF, checked every cycle.
    task automatic run_instr(input int k, input logic [31:0] word, input int wif, input int wmem,
                             input bit zf, input bit lt, input bit abort);
        ent_t e;
        bit   done;
        bit   tk;
        e          = entry(k);
        inst       = word;
        z          = zf;
        flag_small = lt;
        mem_phase({e.name, "_if"}, wif, 1'b0, 1'b0, 1'b0, done);
        if (done) return;

        mem_ready = 1'($urandom);
        #1;
        want    = '0;
        want.st = 3'd2;
        chk_bus({e.name, "_id"});
        tick();

        if (e.kind == K_BAD) begin
            for (int c = 0; c < 3; c++) begin
                mem_ready = 1'($urandom);
                #1;
                want    = '0;
                want.st = 3'd6;
                chk_bus({e.name, "_trap"});
                chk({e.name, "_illegal"}, 32'({illegal, bus_err}), 32'd2);
                tick();
            end
            do_reset({e.name, "_ill"});
            return;
        end

        mem_ready = 1'($urandom);
        #1;
        tk = (e.br == 1) ? zf : (e.br == 2) ? !zf : lt;
        want        = '0;
        want.st     = 3'd3;
        want.aluc   = e.aluc;
        want.aluimm = e.imm;
        want.shift  = e.sh;
        want.lui    = (e.kind == K_LUI);
        want.sext   = e.imm && !e.sh && (e.kind != K_LUI);
        if (e.kind == K_BR) begin
            want.pcsrc = 2'd1;
            want.pc_we = tk;
        end
        chk_bus({e.name, "_ex"});
        tick();
        if (e.kind == K_BR) begin
            end_ok(e.name);
            return;
        end

        if (e.kind == K_LW || e.kind == K_SW) begin
            mem_phase({e.name, "_mem"}, wmem, 1'b1, e.kind == K_SW, abort, done);
            if (done) return;
            if (e.kind == K_SW) begin
                end_ok(e.name);
                return;
            end
        end

        mem_ready = 1'($urandom);
        #1;
        want       = '0;
        want.st    = 3'd5;
        want.wreg  = 1'b1;
        want.m2reg = (e.kind == K_LW);
        if (e.kind == K_JAL) begin
            want.pc_we = 1'b1;
            want.pcsrc = 2'd3;
        end else if (e.kind == K_JALR) begin
            want.pc_we = 1'b1;
            want.pcsrc = 2'd2;
        end
        chk_bus({e.name, "_wb"});
        tick();
        end_ok(e.name);
    endtask

    initial begin
        int k;
        inst       = 32'h0;
        z          = 1'b0;
        flag_small = 1'b0;
        mem_ready  = 1'b0;
        resetn     = 1'b0;
        tick();
        do_reset("init");

        run_instr(0,  32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16, 32'h0080A283, 0, 3, 1'b0, 1'b0, 1'b0);
        run_instr(18, 32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(18, 32'h00208463, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(21, 32'h008000EF, 1, 0, 1'b0, 1'b0, 1'b0);
        run_instr(23, 32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(0,  32'h002081B3, TIMEOUT - 1, 0, 1'b0, 1'b0, 1'b0);
        run_instr(0,  32'h002081B3, TIMEOUT, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16, 32'h0080A283, 12, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        run_instr(16, 32'h0080A283, 0, TIMEOUT, 1'b0, 1'b0, 1'b0);
        run_instr(17, encode(entry(17)), 0, 3, 1'b0, 1'b0, 1'b1);
        run_instr(20, encode(entry(20)), 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr(19, encode(entry(19)), 0, 0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 24);
            run_instr(k, encode(entry(k)), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
